// File: rtl/onehot_sequencer_if.sv
// rtl/onehot_sequencer_if.sv - control and output bundle of the one-hot index sequencer
//
// Purpose: groups the sequencer controls and its decoder-facing outputs.
// Signals:
//   run      - enable prescaler counting and index advance
//   mode     - 00 up, 01 down, 10 ping-pong, 11 hold
//   period   - an advance occurs every period+1 counting cycles
//   load     - synchronous load of load_idx (highest priority)
//   load_idx - index written on load
//   idx      - current index, feeds the 3-to-8 decoder
//   step     - registered pulse, high while idx holds a newly advanced value
//   dir      - current direction, 1 = increasing
// Modports: master drives the controls, slave is the sequencer itself.
interface onehot_sequencer_if #(
    parameter int DIV_W = 8
);
    logic             run;
    logic [1:0]       mode;
    logic [DIV_W-1:0] period;
    logic             load;
    logic [2:0]       load_idx;
    logic [2:0]       idx;
    logic             step;
    logic             dir;

    modport master (
        output run, mode, period, load, load_idx,
        input  idx, step, dir
    );

    modport slave (
        input  run, mode, period, load, load_idx,
        output idx, step, dir
    );
endinterface

// File: rtl/onehot_sequencer.sv
// rtl/onehot_sequencer.sv - prescaled up/down/ping-pong/hold index sequencer for a 3-to-8 decoder
//
// Purpose: generates the 3-bit index that selects which decoder output is lit,
// advancing it every period+1 counting cycles in the selected pattern.
// Ports:
//   clk   - clock, all state changes on its rising edge
//   rst_n - asynchronous active-low reset (cnt=0, idx=0, dir=1, step=0)
//   bus   - onehot_sequencer_if slave: run/mode/period/load/load_idx in,
//           idx/step/dir out (all outputs registered)
module onehot_sequencer #(
    parameter int DIV_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    onehot_sequencer_if.slave  bus
);
    localparam logic [1:0] MODE_UP   = 2'b00;
    localparam logic [1:0] MODE_DOWN = 2'b01;
    localparam logic [1:0] MODE_PING = 2'b10;
    localparam logic [1:0] MODE_HOLD = 2'b11;

    logic [DIV_W-1:0] r_cnt;
    logic [2:0]       r_idx;
    logic             r_dir;
    logic             r_step;

    logic [DIV_W-1:0] w_cnt_nxt;
    logic [2:0]       w_idx_nxt;
    logic             w_dir_nxt;
    logic             w_step_nxt;
    logic [2:0]       w_adv_idx;
    logic             w_adv_dir;

    // Index and direction that an advance would produce in the current mode.
    always_comb begin
        w_adv_idx = r_idx;
        w_adv_dir = r_dir;
        unique case (bus.mode)
            MODE_UP: begin
                w_adv_idx = r_idx + 3'd1;
                w_adv_dir = 1'b1;
            end
            MODE_DOWN: begin
                w_adv_idx = r_idx - 3'd1;
                w_adv_dir = 1'b0;
            end
            MODE_PING: begin
                // Endpoints turn around immediately so each is visited once per cycle.
                if (r_dir) begin
                    if (r_idx == 3'd7) begin
                        w_adv_idx = 3'd6;
                        w_adv_dir = 1'b0;
                    end else begin
                        w_adv_idx = r_idx + 3'd1;
                    end
                end else begin
                    if (r_idx == 3'd0) begin
                        w_adv_idx = 3'd1;
                        w_adv_dir = 1'b1;
                    end else begin
                        w_adv_idx = r_idx - 3'd1;
                    end
                end
            end
            MODE_HOLD: begin
                w_adv_idx = r_idx;
                w_adv_dir = r_dir;
            end
            default: begin
                w_adv_idx = r_idx;
                w_adv_dir = r_dir;
            end
        endcase
    end

    // Priority: load > hold mode > run=0 > counting.
    always_comb begin
        w_cnt_nxt  = r_cnt;
        w_idx_nxt  = r_idx;
        w_dir_nxt  = r_dir;
        w_step_nxt = 1'b0;
        if (bus.load) begin
            w_idx_nxt = bus.load_idx;
            w_cnt_nxt = '0;
            // Loading the top endpoint points the bounce downward.
            w_dir_nxt = (bus.load_idx != 3'd7);
        end else if (bus.mode == MODE_HOLD) begin
            w_cnt_nxt = '0;
        end else if (!bus.run) begin
            w_cnt_nxt = r_cnt;
        end else if (r_cnt >= bus.period) begin
            // >= so a period lowered below the running count fires on the next edge.
            w_cnt_nxt  = '0;
            w_idx_nxt  = w_adv_idx;
            w_dir_nxt  = w_adv_dir;
            w_step_nxt = 1'b1;
        end else begin
            w_cnt_nxt = r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_idx  <= 3'd0;
            r_dir  <= 1'b1;
            r_step <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_idx  <= w_idx_nxt;
            r_dir  <= w_dir_nxt;
            r_step <= w_step_nxt;
        end
    end

    assign bus.idx  = r_idx;
    assign bus.dir  = r_dir;
    assign bus.step = r_step;
endmodule
